ti_quad_stage: RTL and testbench

TI_QUAD_STAGE -- requirements
Module: ti_quad_stage

---
 rtl/ti_quad_pkg.sv | 27 ++
 rtl/ti_quad_if.sv | 28 ++
 rtl/ti_quad_comp.sv | 20 ++
 rtl/ti_quad_stage.sv | 133 +++++++++++++
 tb/tb_ti_quad_stage.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/ti_quad_pkg.sv
// Shared types and constants for the threshold-implemented quadratic S-box stage.
// Share width, share count, the FSM state type and the unshared reference of Q(x).
// The optional skid buffer is enabled in the stage by defining TI_QUAD_SKID_EN.
package ti_quad_pkg;

  localparam int SHARE_W    = 4;
  localparam int NUM_SHARES = 3;

  typedef logic [SHARE_W-1:0] share_t;

  // Main output register occupancy
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } stage_state_t;

  // Unshared Q(x); reference model only, never instantiated in hardware
  function automatic share_t q_ref(input share_t x);
    share_t r;
    r[3] = x[3];
    r[2] = x[2];
    r[1] = x[1] ^ (x[3] & x[2]);
    r[0] = x[0] ^ (x[2] & x[1]);
    return r;
  endfunction

endpackage

// File: rtl/ti_quad_if.sv
// Handshake bundle between the Affine stage, this quadratic stage and the next Affine stage.
// No logic inside; slave is the stage side, master is the surrounding pipeline side.
// Input side transfers on in_valid&in_ready, output side on out_valid&out_ready.
interface ti_quad_if;
  import ti_quad_pkg::*;

  logic   in_valid;
  logic   in_ready;
  share_t x1;
  share_t x2;
  share_t x3;
  logic   out_valid;
  logic   out_ready;
  share_t y1;
  share_t y2;
  share_t y3;

  modport slave (
    input  in_valid, x1, x2, x3, out_ready,
    output in_ready, out_valid, y1, y2, y3
  );

  modport master (
    output in_valid, x1, x2, x3, out_ready,
    input  in_ready, out_valid, y1, y2, y3
  );

endinterface

// File: rtl/ti_quad_comp.sv
// One non-complete component of the shared Q(x): output share i from shares i+1 (a) and i+2 (b).
// Purely combinational, zero latency; registering happens in the enclosing stage.
// No handshake; the caller rotates the share inputs cyclically per instance.
module ti_quad_comp
  import ti_quad_pkg::*;
(
  input  share_t a,
  input  share_t b,
  output share_t y
);

  // Linear bits pass straight from share a; cross terms pair a with b so share i never sees x_i
  always_comb begin
    y[3] = a[3];
    y[2] = a[2];
    y[1] = a[1] ^ (a[3] & a[2]) ^ (a[3] & b[2]) ^ (b[3] & a[2]);
    y[0] = a[0] ^ (a[2] & a[1]) ^ (a[2] & b[1]) ^ (b[2] & a[1]);
  end

endmodule

// File: rtl/ti_quad_stage.sv
// Registered three-share threshold stage computing Q(x) with no fresh randomness.
// Latency 1 cycle; full throughput with no bubble on simultaneous accept.
// Backpressure: in_ready=~out_valid|out_ready, or with TI_QUAD_SKID_EN a registered in_ready via a 1-entry skid.
module ti_quad_stage
  import ti_quad_pkg::*;
#(
  parameter bit CLR_IDLE = 1'b0
)(
  input  logic         clk,
  input  logic         rst_n,
  ti_quad_if.slave     bus
);

  stage_state_t state_q, state_d;
  logic   in_acc, out_acc;
  logic   load_main, clr_main;
  share_t src1, src2, src3;
  share_t c1, c2, c3;
  share_t y1_q, y2_q, y3_q;

`ifdef TI_QUAD_SKID_EN
  logic   skid_valid_q, skid_valid_d, skid_load;
  share_t skid1_q, skid2_q, skid3_q;

  assign bus.in_ready = ~skid_valid_q;
  // A waiting skid entry is always older than the live input, so it wins the main register
  assign src1 = skid_valid_q ? skid1_q : bus.x1;
  assign src2 = skid_valid_q ? skid2_q : bus.x2;
  assign src3 = skid_valid_q ? skid3_q : bus.x3;
`else
  assign bus.in_ready = (state_q == EMPTY) | bus.out_ready;
  assign src1 = bus.x1;
  assign src2 = bus.x2;
  assign src3 = bus.x3;
`endif

  assign bus.out_valid = (state_q == FULL);
  assign in_acc  = bus.in_valid & bus.in_ready;
  assign out_acc = bus.out_valid & bus.out_ready;
  assign bus.y1  = y1_q;
  assign bus.y2  = y2_q;
  assign bus.y3  = y3_q;

  ti_quad_comp u_comp1 (.a(src2), .b(src3), .y(c1));
  ti_quad_comp u_comp2 (.a(src3), .b(src1), .y(c2));
  ti_quad_comp u_comp3 (.a(src1), .b(src2), .y(c3));

  // Next-state and register enables for the main register (and skid when present)
  always_comb begin
    state_d   = state_q;
    load_main = 1'b0;
    clr_main  = 1'b0;
`ifdef TI_QUAD_SKID_EN
    skid_valid_d = skid_valid_q;
    skid_load    = 1'b0;
`endif
    case (state_q)
      EMPTY: begin
        if (in_acc) begin
          state_d   = FULL;
          load_main = 1'b1;
        end
      end
      FULL: begin
`ifdef TI_QUAD_SKID_EN
        if (out_acc) begin
          if (skid_valid_q) begin
            load_main    = 1'b1;
            skid_valid_d = 1'b0;
          end else if (in_acc) begin
            load_main = 1'b1;
          end else begin
            state_d  = EMPTY;
            clr_main = CLR_IDLE;
          end
        end else if (in_acc) begin
          skid_load    = 1'b1;
          skid_valid_d = 1'b1;
        end
`else
        // in_acc while FULL implies out_ready, so the reload replaces the departing word
        if (in_acc) begin
          load_main = 1'b1;
        end else if (out_acc) begin
          state_d  = EMPTY;
          clr_main = CLR_IDLE;
        end
`endif
      end
    endcase
  end

  // Occupancy state and registered output shares
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      y1_q    <= '0;
      y2_q    <= '0;
      y3_q    <= '0;
    end else begin
      state_q <= state_d;
      if (load_main) begin
        y1_q <= c1;
        y2_q <= c2;
        y3_q <= c3;
      end else if (clr_main) begin
        y1_q <= '0;
        y2_q <= '0;
        y3_q <= '0;
      end
    end
  end

`ifdef TI_QUAD_SKID_EN
  // Skid entry holds raw input shares until the main register frees up
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_valid_q <= 1'b0;
      skid1_q      <= '0;
      skid2_q      <= '0;
      skid3_q      <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      if (skid_load) begin
        skid1_q <= bus.x1;
        skid2_q <= bus.x2;
        skid3_q <= bus.x3;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ti_quad_stage.sv
// Directed bench for ti_quad_stage: two instances (CLR_IDLE=0 and 1) driven by the same stream.
// Outputs are sampled 1 time unit after the rising edge; inputs change at the same point.
// Expected values are hand-derived; skid-specific expectations follow TI_QUAD_SKID_EN.
module tb_ti_quad_stage;
  import ti_quad_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  share_t m1, m2;

  always #5 clk = ~clk;

  ti_quad_if ifa ();
  ti_quad_if ifb ();

  assign ifb.in_valid  = ifa.in_valid;
  assign ifb.x1        = ifa.x1;
  assign ifb.x2        = ifa.x2;
  assign ifb.x3        = ifa.x3;
  assign ifb.out_ready = ifa.out_ready;

  ti_quad_stage #(.CLR_IDLE(1'b0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  ti_quad_stage #(.CLR_IDLE(1'b1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input share_t a, input share_t b, input share_t c,
                       input logic ordy);
    ifa.in_valid  = v;
    ifa.x1        = a;
    ifa.x2        = b;
    ifa.x3        = c;
    ifa.out_ready = ordy;
  endtask

  function automatic share_t xa();
    return ifa.y1 ^ ifa.y2 ^ ifa.y3;
  endfunction

  function automatic share_t xb();
    return ifb.y1 ^ ifb.y2 ^ ifb.y3;
  endfunction

  initial begin
    // Reset
    rst_n = 1'b0;
    drive(1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
    #1;
    chk("rst_out_valid", {7'd0, ifa.out_valid}, 8'h00);
    chk("rst_y_a", {ifa.y1, ifa.y2 | ifa.y3}, 8'h00);
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", {7'd0, ifa.in_ready}, 8'h01);
    chk("post_rst_out_valid", {7'd0, ifa.out_valid}, 8'h00);

    // Basic vector: shares (6,0,0) -> y=(0,0,7), Q=7
    drive(1'b1, 4'h6, 4'h0, 4'h0, 1'b1);
    step();
    chk("vec6_out_valid", {7'd0, ifa.out_valid}, 8'h01);
    chk("vec6_y1", {4'h0, ifa.y1}, 8'h00);
    chk("vec6_y2", {4'h0, ifa.y2}, 8'h00);
    chk("vec6_y3", {4'h0, ifa.y3}, 8'h07);
    chk("vec6_xor_a", {4'h0, xa()}, 8'h07);
    chk("vec6_xor_b", {4'h0, xb()}, 8'h07);

    // Random masks with unshared value F -> Q=C
    m1 = share_t'($urandom_range(0, 15));
    m2 = share_t'($urandom_range(0, 15));
    drive(1'b1, m1, m2, 4'hF ^ m1 ^ m2, 1'b1);
    step();
    chk("randF_xor", {4'h0, xa()}, 8'h0C);

    // Exhaustive sweep, back-to-back, random masks
    for (int v = 0; v < 16; v++) begin
      m1 = share_t'($urandom_range(0, 15));
      m2 = share_t'($urandom_range(0, 15));
      drive(1'b1, m1, m2, share_t'(v) ^ m1 ^ m2, 1'b1);
      step();
      chk("sweep_valid", {7'd0, ifa.out_valid}, 8'h01);
      chk("sweep_xor", {4'h0, xa()}, {4'h0, q_ref(share_t'(v))});
    end

    // Non-completeness: base (3,5,9) -> y=(7,9,2), Q(F)=C
    drive(1'b1, 4'h3, 4'h5, 4'h9, 1'b1);
    step();
    chk("nc_base_y1", {4'h0, ifa.y1}, 8'h07);
    chk("nc_base_y2", {4'h0, ifa.y2}, 8'h09);
    chk("nc_base_y3", {4'h0, ifa.y3}, 8'h02);
    chk("nc_base_xor", {4'h0, xa()}, 8'h0C);
    drive(1'b1, 4'hC, 4'h5, 4'h9, 1'b1);
    step();
    chk("nc_tog_x1_y1", {4'h0, ifa.y1}, 8'h07);
    drive(1'b1, 4'h3, 4'hA, 4'h9, 1'b1);
    step();
    chk("nc_tog_x2_y2", {4'h0, ifa.y2}, 8'h09);
    drive(1'b1, 4'h3, 4'h5, 4'h6, 1'b1);
    step();
    chk("nc_tog_x3_y3", {4'h0, ifa.y3}, 8'h02);

    // Backpressure: load (6,0,0), then stall 3 cycles with a live stream C, D, E
    drive(1'b1, 4'h6, 4'h0, 4'h0, 1'b1);
    step();
    drive(1'b1, 4'hC, 4'h0, 4'h0, 1'b0);
    #1;
`ifdef TI_QUAD_SKID_EN
    chk("bp_in_ready_c0", {7'd0, ifa.in_ready}, 8'h01);
`else
    chk("bp_in_ready_c0", {7'd0, ifa.in_ready}, 8'h00);
`endif
    step();
    chk("bp_hold0_valid", {7'd0, ifa.out_valid}, 8'h01);
    chk("bp_hold0_y3", {4'h0, ifa.y3}, 8'h07);
    chk("bp_hold0_xor", {4'h0, xa()}, 8'h07);
    drive(1'b1, 4'hD, 4'h0, 4'h0, 1'b0);
    #1;
    chk("bp_in_ready_c1", {7'd0, ifa.in_ready}, 8'h00);
    step();
    chk("bp_hold1_xor", {4'h0, xa()}, 8'h07);
    drive(1'b1, 4'hE, 4'h0, 4'h0, 1'b0);
    step();
    chk("bp_hold2_valid", {7'd0, ifa.out_valid}, 8'h01);
    chk("bp_hold2_y", {ifa.y1 | ifa.y2, ifa.y3}, 8'h07);
    // Release backpressure
    drive(1'b1, 4'hE, 4'h0, 4'h0, 1'b1);
    #1;
`ifdef TI_QUAD_SKID_EN
    chk("bp_rel_in_ready", {7'd0, ifa.in_ready}, 8'h00);
    step();
    chk("bp_rel_skid_xor", {4'h0, xa()}, 8'h0E);
    #1;
    chk("bp_rel_in_ready2", {7'd0, ifa.in_ready}, 8'h01);
    step();
    chk("bp_rel_e_xor", {4'h0, xa()}, 8'h0D);
`else
    chk("bp_rel_in_ready", {7'd0, ifa.in_ready}, 8'h01);
    step();
    chk("bp_rel_e_xor", {4'h0, xa()}, 8'h0D);
`endif
    chk("bp_rel_valid", {7'd0, ifa.out_valid}, 8'h01);

    // Drain: CLR_IDLE=0 keeps stale data, CLR_IDLE=1 zeroes the shares
    drive(1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
    step();
    chk("drain_a_valid", {7'd0, ifa.out_valid}, 8'h00);
    chk("drain_a_stale_xor", {4'h0, xa()}, 8'h0D);
    chk("drain_b_valid", {7'd0, ifb.out_valid}, 8'h00);
    chk("drain_b_y1", {4'h0, ifb.y1}, 8'h00);
    chk("drain_b_y2", {4'h0, ifb.y2}, 8'h00);
    chk("drain_b_y3", {4'h0, ifb.y3}, 8'h00);
    // Idle input leaves registers untouched
    step();
    chk("idle_a_stale_xor", {4'h0, xa()}, 8'h0D);

    // Reset while FULL (and with the skid occupied in the skid build)
    drive(1'b1, 4'h6, 4'h0, 4'h0, 1'b1);
    step();
    drive(1'b1, 4'h3, 4'h0, 4'h0, 1'b0);
    step();
`ifdef TI_QUAD_SKID_EN
    chk("pre_rst_skid_full", {7'd0, ifa.in_ready}, 8'h00);
`endif
    chk("pre_rst_valid", {7'd0, ifa.out_valid}, 8'h01);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid_a", {7'd0, ifa.out_valid}, 8'h00);
    chk("mid_rst_y_a", {ifa.y1 | ifa.y2, ifa.y3}, 8'h00);
    chk("mid_rst_valid_b", {7'd0, ifb.out_valid}, 8'h00);
    step();
    rst_n = 1'b1;
    drive(1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
    #1;
    chk("rel_in_ready", {7'd0, ifa.in_ready}, 8'h01);
    chk("rel_valid", {7'd0, ifa.out_valid}, 8'h00);
    step();
    chk("rel_no_stale_valid", {7'd0, ifa.out_valid}, 8'h00);
    chk("rel_no_stale_y", {ifa.y1 | ifa.y2, ifa.y3}, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
